irq_controller: RTL
===================

Name: irq_controller

Overview:
- Producer side of the register file's read-only status register (reg0).
- Edge-detects device interrupt requests into sticky pending flags and drives int_flags/busy_flags into the register file.
- Uses the reg1 int_mask byte to raise a single CPU interrupt with a priority-encoded ID.
- Tracks one in-service interrupt until the CPU issues end-of-interrupt (EOI).

Parameters:
- NumLines, 8: number of interrupt/busy lines. Fixed at 8 to match the reg0 byte fields; other values are unsupported.
- IdWidth, $clog2(NumLines): width of interrupt ID fields.

Ports:
- clk  input  1  system clock, rising edge.
- _reset  input  1  asynchronous, active-high reset.
- dev_irq  input  NumLines  device interrupt request levels, synchronous to clk.
- dev_busy  input  NumLines  device busy levels, synchronous to clk.
- int_mask  input  NumLines  enable mask from the register file reg1 high byte.
- irq_take  input  1  CPU accepts the presented interrupt; a single-cycle pulse.
- ack_en  input  1  EOI strobe.
- ack_id  input  IdWidth  ID being acknowledged.
- int_flags  output  NumLines  raw (unmasked) sticky pending flags, to reg0 high byte.
- busy_flags  output  NumLines  registered dev_busy, to reg0 low byte.
- cpu_irq  output  1  interrupt request to the CPU.
- irq_id  output  IdWidth  ID of the presented or in-service interrupt.
- in_service  output  1  an interrupt is being serviced.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - int_flags=0, busy_flags=0, cpu_irq=0, irq_id=0, in_service=0, state=IDLE.
  - Edge-detect history register resets to all-ones, so a line already high at reset release is NOT pended.
- busy_flags: dev_busy registered once; 1-cycle latency, no other processing.
- Edge detect: pend_set[i] = dev_irq[i] & ~prev[i]; prev <= dev_irq every cycle.
- Pending register:
  - pending[i] sets on pend_set[i].
  - pending[i] clears only on a valid EOI for i.
  - Set and clear on the same bit in the same cycle: set wins, so the bit stays 1.
  - int_flags = pending.
- Eligible vector: pending & int_mask. Priority is lowest index highest.
- Latency: a dev_irq rising edge sampled at edge N gives int_flags at N+1 and cpu_irq at N+2 (mask already set).
- FSM states: IDLE, PENDING, SERVICE.
- IDLE:
  - cpu_irq=0, in_service=0.
  - If eligible!=0, go to PENDING and register irq_id = highest-priority eligible.
- PENDING:
  - cpu_irq=1; irq_id re-registers every cycle to the current highest-priority eligible line, so a higher-priority arrival preempts before take.
  - If eligible becomes 0 (mask cleared): go to IDLE, cpu_irq drops the next cycle, irq_id holds its last value.
  - irq_take=1: go to SERVICE; irq_id freezes at its registered value; cpu_irq=0 from the next cycle. Take in the same cycle that eligible goes to 0 also goes to SERVICE (take wins).
- SERVICE:
  - in_service=1, cpu_irq=0, irq_id frozen.
  - ack_en=1 with ack_id==irq_id: clear pending[irq_id] (subject to set-wins), go to IDLE.
  - ack_en with a mismatched ack_id is ignored: state and pending unchanged.
  - New edges on any line still set pending; no nesting.
- ack_en in IDLE/PENDING is ignored. irq_take outside PENDING is ignored.
- Back-to-back: after EOI, IDLE re-evaluates the next cycle. A remaining eligible line therefore raises cpu_irq 2 cycles after the EOI cycle.
- Reset mid-operation: everything returns to reset values immediately, any in-service interrupt is lost, and no EOI is required afterwards.

Decomposition:
- irq_pkg:
  - irq_state_t enum {IDLE, PENDING, SERVICE}.
  - localparams NumIrqLines=8 and IrqIdWidth=3, shared with register_file's regflags_t/regmask_t sizing.
- Sub-module irq_priority_enc:
  - Combinational; NumLines vector in, outputs any and IdWidth index.
  - Lowest set index wins.

Test Plan:
- Reset with dev_irq=8'h04 held high, release, hold for 10 cycles -> int_flags stays 8'h00 and cpu_irq stays 0. Then drop and re-raise bit 2 -> int_flags=8'h04 one cycle after the edge sample.
- int_mask=8'hFF, pulse dev_irq[5] -> cpu_irq=1 at N+2, irq_id=5. irq_take -> in_service=1, cpu_irq=0. ack_en with ack_id=5 -> int_flags=8'h00, state IDLE.
- Pend 5 and 1 together, mask 8'hFF -> irq_id=1. Take, EOI(1) -> cpu_irq re-raised 2 cycles later with irq_id=5.
- In PENDING with irq_id=5, pulse dev_irq[0] -> irq_id becomes 0 before take. In SERVICE(0), ack_id=3 -> ignored, in_service stays 1.
- int_mask=8'h00, pend bit 3 -> int_flags=8'h08 and cpu_irq=0. Set mask=8'h08 -> cpu_irq rises one cycle later. Clear mask while PENDING -> back to IDLE, cpu_irq=0.
- In SERVICE(4), a new dev_irq[4] edge in the same cycle as EOI(4) -> int_flags bit 4 remains 1 and cpu_irq re-raises. dev_busy=8'hA5 -> busy_flags=8'hA5 one cycle later. Reset asserted mid-SERVICE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and sizing for the interrupt controller and the register file's
// reg0/reg1 flag and mask fields.
package irq_pkg;

    localparam int NumIrqLines = 8;
    localparam int IrqIdWidth  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Combinational priority encoder: lowest set index wins.
module irq_priority_enc #(
    parameter int NumLines = 8,
    parameter int IdWidth  = $clog2(NumLines)
) (
    input  logic [NumLines-1:0] req,
    output logic                any,
    output logic [IdWidth-1:0]  idx
);

    // Scan from the top down so the lowest set bit is written last and wins.
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = NumLines - 1; i >= 0; i--) begin
            if (req[i]) idx = IdWidth'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detects device requests into sticky pending
// flags, presents the highest-priority enabled one to the CPU and tracks a
// single in-service interrupt until EOI.
module irq_controller
    import irq_pkg::*;
#(
    parameter int NumLines = NumIrqLines,
    parameter int IdWidth  = $clog2(NumLines)
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic [NumLines-1:0] dev_irq,
    input  logic [NumLines-1:0] dev_busy,
    input  logic [NumLines-1:0] int_mask,
    input  logic                irq_take,
    input  logic                ack_en,
    input  logic [IdWidth-1:0]  ack_id,
    output logic [NumLines-1:0] int_flags,
    output logic [NumLines-1:0] busy_flags,
    output logic                cpu_irq,
    output logic [IdWidth-1:0]  irq_id,
    output logic                in_service
);

    irq_state_t          state;
    logic [NumLines-1:0] prev;
    logic [NumLines-1:0] pending;
    logic [NumLines-1:0] pend_set;
    logic [NumLines-1:0] pend_clr;
    logic [NumLines-1:0] eligible;
    logic                elig_any;
    logic [IdWidth-1:0]  elig_id;
    logic                eoi_hit;

    assign pend_set  = dev_irq & ~prev;
    assign eligible  = pending & int_mask;
    assign int_flags = pending;
    assign eoi_hit   = (state == SERVICE) && ack_en && (ack_id == irq_id);

    irq_priority_enc #(
        .NumLines (NumLines),
        .IdWidth  (IdWidth)
    ) u_enc (
        .req (eligible),
        .any (elig_any),
        .idx (elig_id)
    );

    // Only a matching EOI in SERVICE clears a pending bit.
    always_comb begin
        pend_clr = '0;
        if (eoi_hit) pend_clr[irq_id] = 1'b1;
    end

    // Busy levels are just registered for reg0.
    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) busy_flags <= '0;
        else        busy_flags <= dev_busy;
    end

    // History resets to all-ones so lines already high at reset release are
    // not treated as fresh edges; set is applied after clear so set wins.
    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            prev    <= '1;
            pending <= '0;
        end else begin
            prev    <= dev_irq;
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    // Present / service FSM with registered outputs.
    always_ff @(posedge clk or posedge _reset) begin
        if (_reset) begin
            state      <= IDLE;
            cpu_irq    <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_service <= 1'b0;
                    if (elig_any) begin
                        state   <= PENDING;
                        cpu_irq <= 1'b1;
                        irq_id  <= elig_id;
                    end else begin
                        cpu_irq <= 1'b0;
                    end
                end
                PENDING: begin
                    // Take beats a simultaneous loss of eligibility.
                    if (irq_take) begin
                        state      <= SERVICE;
                        cpu_irq    <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!elig_any) begin
                        state   <= IDLE;
                        cpu_irq <= 1'b0;
                    end else begin
                        cpu_irq <= 1'b1;
                        irq_id  <= elig_id;
                    end
                end
                SERVICE: begin
                    cpu_irq <= 1'b0;
                    if (eoi_hit) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end else begin
                        in_service <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cpu_irq    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule
